flappy_game_ctrl: RTL

Central game sequencer for the Flappy Bird design. It owns the IDLE/PLAY/DYING/OVER state machine and generates the per-frame movement tick. It evaluates bird-versus-pipe, floor and ceiling collisions, and keeps the 4-digit BCD score. It sits between the board buttons and the bird, pipe and VGA-colour blocks: it gates their motion through `Run` and feeds `Score` to the seven-segment and VGA paths.

---
 rtl/flappy_pkg.sv | 39 +++
 rtl/flappy_game_ctrl_bcd_counter4.sv | 27 ++
 rtl/flappy_game_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared definitions for the Flappy Bird design.
// Holds the game state encoding, the default playfield geometry that the
// bird, pipe, VGA and game-control blocks agree on, and a BCD increment
// helper used by the score counter.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } gameState_t;

  localparam int unsigned BIRD_SIZE = 16;   // bird square edge, pixels
  localparam int unsigned PIPE_W    = 40;   // pipe width, pixels
  localparam int unsigned GAP_H     = 120;  // vertical gap height, pixels
  localparam int unsigned CEIL_Y    = 35;   // first visible row
  localparam int unsigned FLOOR_Y   = 514;  // last visible row

  // Adds one to a 4-digit packed BCD value; 9999 rolls over to 0000.
  function automatic logic [15:0] bcdInc(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[i*4 +: 4] == 4'd9) begin
          result[i*4 +: 4] = 4'd0;
        end else begin
          result[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/flappy_game_ctrl_bcd_counter4.sv
// bcd_counter4: 4-digit packed BCD counter.
// Ports:
//   Clk   - clock
//   Reset - asynchronous active-low reset (count -> 0000)
//   Clr   - synchronous clear, wins over Inc
//   Inc   - increment by one; 9999 wraps to 0000
//   Count - BCD value, digit 3 in [15:12]
module bcd_counter4 (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Clr,
  input  logic        Inc,
  output logic [15:0] Count
);
  import flappy_pkg::*;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= '0;
    end else if (Inc) begin
      Count <= bcdInc(Count);
    end
  end

endmodule

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: central game sequencer (IDLE/PLAY/DYING/OVER),
// frame tick generator, collision evaluation and BCD scoring.
// Optional feature macro: FLAPPY_HISCORE_EN (keeps a best-score register;
// without it HiScore is tied to 0000).
// Ports:
//   Clk, Reset          - clock, asynchronous active-low reset
//   Start, Flap         - raw buttons, asynchronous to Clk
//   BirdX, BirdY        - bird top-left position
//   PipeX, PipeY        - pipe left edge and gap top row
//   FrameTick           - one-cycle pulse every TICK_DIV cycles
//   Run                 - high in PLAY; enables bird/pipe motion
//   FlapPulse           - one-cycle pulse per flap press while in PLAY
//   Lost                - high in DYING and OVER
//   State               - current state encoding
//   Score, HiScore      - 4-digit BCD current and best score
module flappy_game_ctrl #(
  parameter int unsigned TICK_DIV   = 1666667,
  parameter int unsigned BIRD_SIZE  = flappy_pkg::BIRD_SIZE,
  parameter int unsigned PIPE_W     = flappy_pkg::PIPE_W,
  parameter int unsigned GAP_H      = flappy_pkg::GAP_H,
  parameter int unsigned CEIL_Y     = flappy_pkg::CEIL_Y,
  parameter int unsigned FLOOR_Y    = flappy_pkg::FLOOR_Y,
  parameter int unsigned DIE_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Flap,
  input  logic [9:0]  BirdX,
  input  logic [9:0]  BirdY,
  input  logic [9:0]  PipeX,
  input  logic [9:0]  PipeY,
  output logic        FrameTick,
  output logic        Run,
  output logic        FlapPulse,
  output logic        Lost,
  output logic [1:0]  State,
  output logic [15:0] Score,
  output logic [15:0] HiScore
);
  import flappy_pkg::*;

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam int unsigned DIE_W = $clog2(DIE_FRAMES + 1);
  localparam logic [DIE_W-1:0] DIE_LAST = DIE_W'(DIE_FRAMES - 1);

  localparam logic [10:0] SIZE11  = 11'(BIRD_SIZE);
  localparam logic [10:0] PIPEW11 = 11'(PIPE_W);
  localparam logic [10:0] GAP11   = 11'(GAP_H);
  localparam logic [10:0] CEIL11  = 11'(CEIL_Y);
  localparam logic [10:0] FLOOR11 = 11'(FLOOR_Y);

  gameState_t        state, stateNext;
  logic [2:0]        startSync, flapSync;
  logic              startPulse, flapPulseInt;
  logic [TICK_W-1:0] tickCnt;
  logic [DIE_W-1:0]  dieCnt;
  logic [9:0]        prevPipeX;
  logic              passed;
  logic              scoreClr, scoreInc;
  logic              xOverlap, pipeHit, edgeHit, cleared, wrapped;
  logic [10:0]       bx, by, px, py;

  // Bits [1:0] are the two-flop synchronizer, bit 2 holds the previous
  // synchronized level; the registered pulse lands three edges after the pin.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      startSync    <= '0;
      flapSync     <= '0;
      startPulse   <= 1'b0;
      flapPulseInt <= 1'b0;
    end else begin
      startSync    <= {startSync[1:0], Start};
      flapSync     <= {flapSync[1:0], Flap};
      startPulse   <= startSync[1] & ~startSync[2];
      flapPulseInt <= flapSync[1] & ~flapSync[2];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tickCnt   <= '0;
      FrameTick <= 1'b0;
    end else begin
      FrameTick <= (tickCnt == TICK_LAST);
      tickCnt   <= (tickCnt == TICK_LAST) ? '0 : tickCnt + TICK_W'(1);
    end
  end

  assign bx = {1'b0, BirdX};
  assign by = {1'b0, BirdY};
  assign px = {1'b0, PipeX};
  assign py = {1'b0, PipeY};

  assign xOverlap = (bx + SIZE11 > px) && (bx < px + PIPEW11);
  assign pipeHit  = xOverlap && ((by < py) || (by + SIZE11 > py + GAP11));
  assign edgeHit  = (by <= CEIL11) || (by + SIZE11 - 11'd1 >= FLOOR11);
  assign cleared  = (px + PIPEW11 <= bx);
  assign wrapped  = (PipeX > prevPipeX);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    scoreClr  = 1'b0;
    scoreInc  = 1'b0;
    case (state)
      IDLE: begin
        if (startPulse) begin
          stateNext = PLAY;
          scoreClr  = 1'b1;
        end
      end
      PLAY: begin
        if (FrameTick) begin
          if (pipeHit || edgeHit) begin
            stateNext = DYING;
          end else if (cleared && !passed) begin
            scoreInc = 1'b1;
          end
        end
      end
      DYING: begin
        if (FrameTick && (dieCnt == DIE_LAST)) begin
          stateNext = OVER;
        end
      end
      OVER: begin
        if (startPulse) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // The pass flag uses its value from before the tick for scoring; a pipe
  // wrap on the same tick takes precedence when updating it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      passed    <= 1'b0;
      prevPipeX <= '0;
      dieCnt    <= '0;
      FlapPulse <= 1'b0;
    end else begin
      FlapPulse <= flapPulseInt && (state == PLAY);
      if (FrameTick) begin
        prevPipeX <= PipeX;
      end
      if (scoreClr) begin
        passed <= 1'b0;
      end else if (FrameTick && (state == PLAY)) begin
        if (wrapped) begin
          passed <= 1'b0;
        end else if (scoreInc) begin
          passed <= 1'b1;
        end
      end
      if (state != DYING) begin
        dieCnt <= '0;
      end else if (FrameTick) begin
        dieCnt <= dieCnt + DIE_W'(1);
      end
    end
  end

  bcd_counter4 uScore (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (scoreClr),
    .Inc   (scoreInc),
    .Count (Score)
  );

`ifdef FLAPPY_HISCORE_EN
  logic        dieEnter;
  logic [15:0] hiReg;

  assign dieEnter = (state == PLAY) && (stateNext == DYING);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hiReg <= '0;
    end else if (dieEnter && (Score > hiReg)) begin
      hiReg <= Score;
    end
  end

  assign HiScore = hiReg;
`else
  assign HiScore = '0;
`endif

  assign State = state;
  assign Run   = (state == PLAY);
  assign Lost  = (state == DYING) || (state == OVER);

endmodule
